// File: rtl/trace_pkg.sv
// Shared types and constants for the TPIU trace transmitter.
// Width-code helpers, sync words and the unit state enum.
package trace_pkg;

    localparam int FRAME_BITS = 128;

    localparam logic [31:0] TPIU_FSYNC = 32'h7FFF_FFFF;
    localparam logic [15:0] TPIU_HSYNC = 16'h7FFF;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_FRAME = 2'd1,
        ST_IDLE  = 2'd2
    } state_t;

    // Pins used per edge for a width code.
    function automatic logic [2:0] w_of(input logic [1:0] code);
        case (code)
            2'd3:    return 3'd4;
            2'd2:    return 3'd2;
            default: return 3'd1;
        endcase
    endfunction

    // Beats needed to carry one byte for a width code.
    function automatic logic [2:0] bpb_of(input logic [1:0] code);
        case (code)
            2'd3:    return 3'd1;
            2'd2:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Length of each unit in bytes.
    function automatic logic [4:0] unit_bytes(input state_t s);
        case (s)
            ST_SYNC:  return 5'd4;
            ST_FRAME: return 5'd16;
            default:  return 5'd2;
        endcase
    endfunction

endpackage

// File: rtl/trace_tx_if.sv
// Frame handshake bundle between a frame source and the transmitter.
// Source is master; the transmitter is slave.
interface trace_tx_if;
    import trace_pkg::*;

    logic                  FrValid;
    logic [FRAME_BITS-1:0] Frame;
    logic                  FrReady;

    modport master (output FrValid, output Frame, input FrReady);
    modport slave  (input FrValid, input Frame, output FrReady);

endinterface

// File: rtl/trace_beat_ser.sv
// Byte-to-beat serialiser: picks the 2w bits of the current beat,
// LSB first, and zeroes every pin at or above w.
module trace_beat_ser
    import trace_pkg::*;
#(
    parameter int MAXBUSWIDTH = 4
) (
    input  logic [7:0]             i_byte,
    input  logic [1:0]             i_beat,
    input  logic [1:0]             i_wcode,
    output logic [MAXBUSWIDTH-1:0] o_a,
    output logic [MAXBUSWIDTH-1:0] o_b
);

    logic [2:0] w_w;
    logic [3:0] w_sh;
    logic [7:0] w_mask;
    logic [7:0] w_rem;
    logic [7:0] w_a8;
    logic [7:0] w_b8;

    // Drop the bits already sent, then split the rest into a/b halves
    always_comb begin
        w_w    = w_of(i_wcode);
        w_sh   = 4'(w_w) * {2'b00, i_beat};
        w_mask = (8'd1 << w_w) - 8'd1;
        w_rem  = i_byte >> {w_sh, 1'b0};
        w_a8   = w_rem & w_mask;
        w_b8   = (w_rem >> w_w) & w_mask;
    end

    assign o_a = w_a8[MAXBUSWIDTH-1:0];
    assign o_b = w_b8[MAXBUSWIDTH-1:0];

endmodule

// File: rtl/trace_tx.sv
// TPIU trace port transmitter: sends sync, frame and idle units
// back to back onto a DDR trace bus of 1, 2 or 4 pins per edge.
module trace_tx
    import trace_pkg::*;
#(
    parameter int MAXBUSWIDTH = 4,
    parameter int SYNC_BITS   = 20
) (
    input  logic                   traceClkin,
    input  logic                   rst,
    input  logic [1:0]             width,
    trace_tx_if.slave              fr,
    output logic [MAXBUSWIDTH-1:0] traceDouta,
    output logic [MAXBUSWIDTH-1:0] traceDoutb,
    output logic                   syncOut,
    output logic                   idle
);

    state_t                 r_state;
    logic [3:0]             r_byte;
    logic [1:0]             r_beat;
    logic [1:0]             r_wc;
    logic [FRAME_BITS-1:0]  r_shreg;
    logic [SYNC_BITS-1:0]   r_cnt;
    logic                   r_due;
    logic [MAXBUSWIDTH-1:0] r_douta;
    logic [MAXBUSWIDTH-1:0] r_doutb;
    logic                   r_sync;
    logic                   r_idle;

    logic                   w_last_beat;
    logic                   w_last;
    logic                   w_first;
    logic                   w_sync_sel;
    logic                   w_ready;
    logic                   w_take;
    logic [7:0]             w_cur_byte;
    logic [MAXBUSWIDTH-1:0] w_a;
    logic [MAXBUSWIDTH-1:0] w_b;

    assign w_last_beat = ({1'b0, r_beat} == (bpb_of(r_wc) - 3'd1));
    assign w_last      = w_last_beat &&
                         ({1'b0, r_byte} == (unit_bytes(r_state) - 5'd1));
    assign w_first     = (r_byte == 4'd0) && (r_beat == 2'd0);
    assign w_sync_sel  = r_due || (width != r_wc);
    assign w_ready     = !rst && w_last && !w_sync_sel;
    assign w_take      = w_ready && fr.FrValid;
    assign fr.FrReady  = w_ready;

    // Byte of the current unit that is being serialised
    always_comb begin
        w_cur_byte = r_shreg[FRAME_BITS-1 -: 8];
        case (r_state)
            ST_SYNC: w_cur_byte = TPIU_FSYNC[{r_byte[1:0], 3'b000} +: 8];
            ST_IDLE: w_cur_byte = TPIU_HSYNC[{r_byte[0], 3'b000} +: 8];
            default: w_cur_byte = r_shreg[FRAME_BITS-1 -: 8];
        endcase
    end

    trace_beat_ser #(
        .MAXBUSWIDTH (MAXBUSWIDTH)
    ) u_ser (
        .i_byte  (w_cur_byte),
        .i_beat  (r_beat),
        .i_wcode (r_wc),
        .o_a     (w_a),
        .o_b     (w_b)
    );

    // Unit FSM: emit current beat, advance pointer, pick next unit
    always_ff @(posedge traceClkin) begin
        if (rst) begin
            r_state <= ST_SYNC;
            r_byte  <= 4'd0;
            r_beat  <= 2'd0;
            r_wc    <= width;
            r_cnt   <= '1;
            r_due   <= 1'b0;
            r_douta <= '0;
            r_doutb <= '0;
            r_sync  <= 1'b0;
            r_idle  <= 1'b0;
        end else begin
            r_douta <= w_a;
            r_doutb <= w_b;
            r_sync  <= (r_state == ST_SYNC) && w_first;
            r_idle  <= (r_state == ST_IDLE);

            if ((r_state == ST_SYNC) && w_first) begin
                r_cnt <= '1;
                r_due <= 1'b0;
            end else if (r_cnt == '0) begin
                r_due <= 1'b1;
            end else begin
                r_cnt <= r_cnt - SYNC_BITS'(1);
            end

            if (w_last) begin
                r_byte <= 4'd0;
                r_beat <= 2'd0;
                r_wc   <= width;
                if (w_sync_sel) begin
                    r_state <= ST_SYNC;
                end else if (w_take) begin
                    r_state <= ST_FRAME;
                    r_shreg <= fr.Frame;
                end else begin
                    r_state <= ST_IDLE;
                end
            end else if (w_last_beat) begin
                r_beat <= 2'd0;
                r_byte <= r_byte + 4'd1;
                if (r_state == ST_FRAME) begin
                    r_shreg <= {r_shreg[FRAME_BITS-9:0], 8'h00};
                end
            end else begin
                r_beat <= r_beat + 2'd1;
            end
        end
    end

    assign traceDouta = r_douta;
    assign traceDoutb = r_doutb;
    assign syncOut    = r_sync;
    assign idle       = r_idle;

endmodule

// File: tb/tb_trace_tx.sv
// Bench for trace_tx: directed beat checks plus a frame scoreboard
// that rebuilds every sent frame from the DDR pins.
module tb_trace_tx;

    logic       clk;
    logic       rst;
    logic [1:0] width;
    logic [3:0] douta;
    logic [3:0] doutb;
    logic       syncOut;
    logic       idle;

    trace_tx_if fr();

    trace_tx #(
        .MAXBUSWIDTH (4),
        .SYNC_BITS   (6)
    ) dut (
        .traceClkin (clk),
        .rst        (rst),
        .width      (width),
        .fr         (fr),
        .traceDouta (douta),
        .traceDoutb (doutb),
        .syncOut    (syncOut),
        .idle       (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    typedef struct {
        logic [127:0] f;
        logic [1:0]   wc;
        int           start;
    } exp_t;

    exp_t         q[$];
    exp_t         cur;
    int           n_neg   = 0;
    bit           col     = 0;
    int           bitpos  = 0;
    int           wm      = 1;
    int           nframes = 0;
    logic [127:0] acc;
    bit           side_err;

    function automatic int wbits(input logic [1:0] c);
        return (c == 2'd3) ? 4 : (c == 2'd2) ? 2 : 1;
    endfunction

    function automatic int fbit(input int i);
        return 120 - 8 * (i / 8) + (i % 8);
    endfunction

    // Scoreboard: push on transfer, rebuild frame from pins, compare
    always @(negedge clk) begin
        n_neg++;
        if (rst) begin
            col = 0;
            q.delete();
        end else begin
            if (!col && q.size() > 0 && q[0].start < n_neg) begin
                chk("frame_start", 128'(n_neg), 128'(q[0].start));
                void'(q.pop_front());
            end
            if (!col && q.size() > 0 && q[0].start == n_neg) begin
                cur      = q.pop_front();
                col      = 1;
                bitpos   = 0;
                acc      = '0;
                side_err = 0;
                wm       = wbits(cur.wc);
            end
            if (col) begin
                for (int i = 0; i < wm; i++) acc[fbit(bitpos + i)] = douta[i];
                for (int i = 0; i < wm; i++) acc[fbit(bitpos + wm + i)] = doutb[i];
                if ((douta >> wm) != 0 || (doutb >> wm) != 0 || idle)
                    side_err = 1;
                bitpos += 2 * wm;
                if (bitpos >= 128) begin
                    chk("frame_data", acc, cur.f);
                    chk("frame_side", 128'(side_err), 128'(0));
                    col = 0;
                    nframes++;
                end
            end
            if (syncOut) chk("sync_in_frame", 128'(col), 128'(0));
            if (fr.FrValid && fr.FrReady)
                q.push_back('{f: fr.Frame, wc: width, start: n_neg + 2});
        end
    end

    task automatic send_frame(input logic [127:0] f);
        bit done;
        done       = 0;
        fr.Frame   = f;
        fr.FrValid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (fr.FrReady) done = 1;
        end
        if (!done) chk("send_timeout", 128'(0), 128'(1));
        @(posedge clk);
        #1;
        fr.FrValid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0]   a5_exp [4];
    logic [127:0] f6;
    logic [7:0]   b7;
    logic [3:0]   eb;
    int           gap_last;
    int           cyc;
    int           nsync;
    bit           sawsync;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        a5_exp     = '{8'h10, 8'h10, 8'h01, 8'h01};
        rst        = 1'b1;
        width      = 2'd3;
        fr.FrValid = 1'b0;
        fr.Frame   = '0;
        repeat (3) step();
        chk("rst_out", 128'({douta, doutb, syncOut, idle}), 128'(0));
        chk("rst_rdy", 128'(fr.FrReady), 128'(0));
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step();
            if (i < 4) eb = (i == 3) ? 4'h7 : 4'hF;
            else       eb = ((i - 4) % 2 == 1) ? 4'h7 : 4'hF;
            chk("sync_idle_seq", 128'({douta, doutb, syncOut, idle}),
                128'({4'hF, eb, (i == 0), (i >= 4)}));
        end

        send_frame(128'h00112233_44556677_8899AABB_CCDDEEFF);
        for (int k = 0; k < 16; k++) begin
            step();
            chk("w4_beat", 128'({douta, doutb, idle}),
                128'({4'(k), 4'(k), 1'b0}));
        end

        width = 2'd0;
        send_frame({8'hA5, 120'h0123_4567_89AB_CDEF_0011_2233_4455_66});
        for (int k = 0; k < 4; k++) begin
            step();
            chk("w1_a5_beat", 128'({douta, doutb}), 128'(a5_exp[k]));
        end

        width      = 2'd2;
        fr.Frame   = {$urandom, $urandom, $urandom, $urandom};
        fr.FrValid = 1'b1;
        gap_last   = -1;
        cyc        = 0;
        nsync      = 0;
        sawsync    = 0;
        repeat (320) begin
            @(negedge clk);
            cyc++;
            if (syncOut) begin
                sawsync = 1;
                nsync++;
            end
            if (fr.FrReady) begin
                if (gap_last >= 0)
                    chk("b2b_gap", 128'(cyc - gap_last),
                        128'(sawsync ? 40 : 32));
                gap_last = cyc;
                sawsync  = 0;
                @(posedge clk);
                #1;
                fr.Frame = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        step();
        fr.FrValid = 1'b0;
        chk("periodic_sync", 128'(nsync > 2), 128'(1));

        width = 2'd3;
        send_frame({$urandom, $urandom, $urandom, $urandom});
        repeat (8) step();
        width = 2'd2;
        repeat (9) step();
        chk("wchg_sync", 128'({douta, doutb, syncOut}),
            128'({4'h3, 4'h3, 1'b1}));

        width = 2'd3;
        f6    = {$urandom, $urandom, $urandom, $urandom};
        b7    = f6[71:64];
        send_frame(f6);
        repeat (8) step();
        chk("byte7_beat", 128'({douta, doutb}), 128'({b7[3:0], b7[7:4]}));
        rst = 1'b1;
        step();
        chk("rst_mid_out", 128'({douta, doutb, syncOut, idle}), 128'(0));
        chk("rst_mid_rdy", 128'(fr.FrReady), 128'(0));
        step();
        rst = 1'b0;
        step();
        chk("rst_resync", 128'({douta, doutb, syncOut, idle}),
            128'({4'hF, 4'hF, 1'b1, 1'b0}));

        send_frame({$urandom, $urandom, $urandom, $urandom});
        repeat (40) step();
        chk("sb_drain", 128'(q.size() + int'(col)), 128'(0));
        chk("sb_seen", 128'(nframes >= 8), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
